// File: rtl/taint_sum_scanner.sv
`default_nettype none
// ============================================================================
// Module   : taint_sum_scanner
// Purpose  : Taint-monitoring sequencer.
//            - Snapshots the taint_sum buses of N_CELLS tracked cells.
//            - Walks the snapshot one cell per cycle and streams a record for
//              every nonzero entry over a valid/ready port.
//            - Timestamps the first cycle in which any live cell is tainted.
// Ports    : clock, reset      - rising-edge clock, synchronous active-high reset
//            sum_in            - packed cell sums, cell i at [i*SUM_WIDTH +: SUM_WIDTH]
//            scan_req, period  - manual scan request / auto-scan interval (0 = off)
//            clear_first       - clears the first-taint record
//            busy, done        - scan in progress / one-cycle end-of-scan pulse
//            rec_*             - record stream (valid/ready, index, value, last)
//            total             - sum of all snapshot entries, valid from done
//            first_*           - sticky first-taint flag, timestamp and index
// Revision : 1.0  initial release
// ============================================================================
module taint_sum_scanner #(
   parameter  int N_CELLS   = 8,
   parameter  int SUM_WIDTH = 8,
   parameter  int CNT_WIDTH = 32,
   localparam int IDXW      = $clog2(N_CELLS)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [N_CELLS*SUM_WIDTH-1:0] sum_in,
   input  logic                         scan_req,
   input  logic [15:0]                  period,
   input  logic                         clear_first,
   output logic                         busy,
   output logic                         rec_valid,
   input  logic                         rec_ready,
   output logic [IDXW-1:0]              rec_idx,
   output logic [SUM_WIDTH-1:0]         rec_sum,
   output logic                         rec_last,
   output logic                         done,
   output logic [SUM_WIDTH+IDXW-1:0]    total,
   output logic                         first_valid,
   output logic [CNT_WIDTH-1:0]         first_cycle,
   output logic [IDXW-1:0]              first_idx
);

   localparam int              TW      = SUM_WIDTH + IDXW;
   localparam logic [IDXW-1:0] IDX_MAX = IDXW'(N_CELLS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_EMIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                 state;
   state_t                 state_nxt;

   logic [SUM_WIDTH-1:0]   snap [N_CELLS];
   logic [IDXW-1:0]        idx;
   logic [IDXW-1:0]        last_idx;
   logic                   last_any;
   logic                   pending;
   logic [15:0]            timer;
   logic [CNT_WIDTH-1:0]   counter;

   logic                   trig;
   logic                   start;
   logic [SUM_WIDTH-1:0]   cur_sum;
   logic                   live_any;
   logic [IDXW-1:0]        live_low;
   logic [IDXW-1:0]        live_high;

   assign trig    = scan_req | ((period != 16'd0) && (timer == 16'd1));
   assign start   = (state == S_IDLE) && (trig || pending);
   assign cur_sum = snap[idx];

   // Lowest and highest nonzero live cell. The low index feeds the
   // first-taint record; the high index becomes last_idx at snapshot time.
   always_comb begin
      live_any  = 1'b0;
      live_low  = '0;
      live_high = '0;
      for (int i = N_CELLS - 1; i >= 0; i--) begin
         if (sum_in[i*SUM_WIDTH +: SUM_WIDTH] != '0) begin
            live_any = 1'b1;
            live_low = IDXW'(i);
         end
      end
      for (int i = 0; i < N_CELLS; i++) begin
         if (sum_in[i*SUM_WIDTH +: SUM_WIDTH] != '0) begin
            live_high = IDXW'(i);
         end
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      rec_valid = 1'b0;
      rec_idx   = '0;
      rec_sum   = '0;
      rec_last  = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (trig || pending) begin
               state_nxt = S_SCAN;
            end
         end
         S_SCAN: begin
            busy = 1'b1;
            if (cur_sum != '0) begin
               state_nxt = S_EMIT;
            end else if (idx == IDX_MAX) begin
               state_nxt = S_DONE;
            end
         end
         S_EMIT: begin
            busy      = 1'b1;
            rec_valid = 1'b1;
            rec_idx   = idx;
            rec_sum   = cur_sum;
            rec_last  = last_any && (idx == last_idx);
            if (rec_ready) begin
               state_nxt = (rec_last || (idx == IDX_MAX)) ? S_DONE : S_SCAN;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------- scan datapath
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < N_CELLS; i++) begin
            snap[i] <= '0;
         end
         idx      <= '0;
         last_idx <= '0;
         last_any <= 1'b0;
         total    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  for (int i = 0; i < N_CELLS; i++) begin
                     snap[i] <= sum_in[i*SUM_WIDTH +: SUM_WIDTH];
                  end
                  last_idx <= live_high;
                  last_any <= live_any;
                  idx      <= '0;
                  total    <= '0;
               end
            end
            S_SCAN: begin
               // Accumulate exactly once per cell; EMIT never adds.
               total <= total + TW'(cur_sum);
               if ((cur_sum == '0) && (idx != IDX_MAX)) begin
                  idx <= idx + 1'b1;
               end
            end
            S_EMIT: begin
               if (rec_ready && !(rec_last || (idx == IDX_MAX))) begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------- trigger timer and pending
   always_ff @(posedge clock) begin
      if (reset) begin
         timer   <= period;
         pending <= 1'b0;
      end else begin
         // A zero timer with a nonzero period (period just enabled) reloads
         // instead of wrapping.
         if (period == 16'd0) begin
            timer <= 16'd0;
         end else if (timer <= 16'd1) begin
            timer <= period;
         end else begin
            timer <= timer - 16'd1;
         end

         // Any IDLE cycle consumes the pending request; while busy, further
         // triggers collapse into one.
         if (state == S_IDLE) begin
            pending <= 1'b0;
         end else if (trig) begin
            pending <= 1'b1;
         end
      end
   end

   // ------------------------------------------------- first-taint record
   always_ff @(posedge clock) begin
      if (reset) begin
         counter     <= '0;
         first_valid <= 1'b0;
         first_cycle <= '0;
         first_idx   <= '0;
      end else begin
         counter <= counter + 1'b1;
         if (clear_first) begin
            first_valid <= 1'b0;
            first_cycle <= '0;
            first_idx   <= '0;
         end else if (!first_valid && live_any) begin
            first_valid <= 1'b1;
            first_cycle <= counter;
            first_idx   <= live_low;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_taint_sum_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_taint_sum_scanner
// Purpose  : Directed self-checking bench for taint_sum_scanner with
//            hand-computed expected values.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_taint_sum_scanner;

   logic        clock = 1'b0;
   logic        reset;
   logic [63:0] sum_in;
   logic        scan_req;
   logic [15:0] period;
   logic        clear_first;
   logic        busy;
   logic        rec_valid;
   logic        rec_ready;
   logic [2:0]  rec_idx;
   logic [7:0]  rec_sum;
   logic        rec_last;
   logic        done;
   logic [10:0] total;
   logic        first_valid;
   logic [31:0] first_cycle;
   logic [2:0]  first_idx;

   int n_checks = 0;
   int n_pass   = 0;

   logic [63:0] busy_mask;
   logic [63:0] done_mask;
   logic [10:0] tot_done;
   int          nrec;
   int          unstable;
   logic [2:0]  r_idx  [4];
   logic [7:0]  r_sum  [4];
   logic        r_last [4];

   taint_sum_scanner #(
      .N_CELLS   (8),
      .SUM_WIDTH (8),
      .CNT_WIDTH (32)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .sum_in      (sum_in),
      .scan_req    (scan_req),
      .period      (period),
      .clear_first (clear_first),
      .busy        (busy),
      .rec_valid   (rec_valid),
      .rec_ready   (rec_ready),
      .rec_idx     (rec_idx),
      .rec_sum     (rec_sum),
      .rec_last    (rec_last),
      .done        (done),
      .total       (total),
      .first_valid (first_valid),
      .first_cycle (first_cycle),
      .first_idx   (first_idx)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Runs ncyc cycles. scan_req for cycle c is pulses[c]. The first record
   // seen is held off for 'stall' cycles, during which it must not change.
   task automatic monitor(input int ncyc, input int stall, input logic [63:0] pulses);
      int         stall_left;
      logic       holding;
      logic [2:0] h_idx;
      logic [7:0] h_sum;
      logic       h_last;
      busy_mask  = '0;
      done_mask  = '0;
      tot_done   = '0;
      nrec       = 0;
      unstable   = 0;
      stall_left = stall;
      holding    = 1'b0;
      h_idx      = '0;
      h_sum      = '0;
      h_last     = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         busy_mask[c] = busy;
         done_mask[c] = done;
         if (done) tot_done = total;
         rec_ready = 1'b1;
         if (rec_valid) begin
            if (holding && ({rec_idx, rec_sum, rec_last} !== {h_idx, h_sum, h_last}))
               unstable++;
            if (stall_left > 0) begin
               if (!holding) begin
                  h_idx   = rec_idx;
                  h_sum   = rec_sum;
                  h_last  = rec_last;
                  holding = 1'b1;
               end
               rec_ready = 1'b0;
               stall_left--;
            end else begin
               holding = 1'b0;
               if (nrec < 4) begin
                  r_idx[nrec]  = rec_idx;
                  r_sum[nrec]  = rec_sum;
                  r_last[nrec] = rec_last;
               end
               nrec++;
            end
         end
         scan_req = pulses[c];
         step();
      end
      scan_req  = 1'b0;
      rec_ready = 1'b1;
   endtask

   initial begin
      int starts [3];
      int nstart;
      int busy_cnt;
      logic prev_busy;

      reset       = 1'b1;
      sum_in      = '0;
      scan_req    = 1'b0;
      period      = 16'd0;
      clear_first = 1'b0;
      rec_ready   = 1'b1;
      repeat (3) step();

      check("reset_busy",        busy,        1'b0);
      check("reset_rec_valid",   rec_valid,   1'b0);
      check("reset_done",        done,        1'b0);
      check("reset_total",       total,       11'd0);
      check("reset_first_valid", first_valid, 1'b0);

      // ---------------- first-taint timestamp (counter = k-1 at edge k)
      reset = 1'b0;
      repeat (37) step();
      sum_in[6*8 +: 8] = 8'd5;
      step();
      check("first_valid_a", first_valid, 1'b1);
      check("first_cycle_a", first_cycle, 32'd37);
      check("first_idx_a",   first_idx,   3'd6);
      repeat (2) step();
      sum_in[3*8 +: 8] = 8'd2;
      step();
      check("first_sticky_cycle", first_cycle, 32'd37);
      check("first_sticky_idx",   first_idx,   3'd6);
      step();
      clear_first      = 1'b1;
      sum_in[6*8 +: 8] = 8'd0;
      step();
      check("clear_wins", first_valid, 1'b0);
      clear_first = 1'b0;
      step();
      check("relatch_valid", first_valid, 1'b1);
      check("relatch_cycle", first_cycle, 32'd43);
      check("relatch_idx",   first_idx,   3'd3);

      // ---------------- all-zero scan
      sum_in = '0;
      step();
      monitor(20, 0, 64'h1);
      check("zero_busy_mask", busy_mask, 64'h3FE);
      check("zero_done_mask", done_mask, 64'h200);
      check("zero_nrec",      nrec,      0);
      check("zero_total",     tot_done,  11'd0);

      // ---------------- two nonzero cells, rec_ready always high
      sum_in[2*8 +: 8] = 8'd3;
      sum_in[5*8 +: 8] = 8'd1;
      monitor(20, 0, 64'h1);
      check("two_nrec",      nrec,      2);
      check("two_rec0_idx",  r_idx[0],  3'd2);
      check("two_rec0_sum",  r_sum[0],  8'd3);
      check("two_rec0_last", r_last[0], 1'b0);
      check("two_rec1_idx",  r_idx[1],  3'd5);
      check("two_rec1_sum",  r_sum[1],  8'd1);
      check("two_rec1_last", r_last[1], 1'b1);
      check("two_total",     tot_done,  11'd4);
      check("two_busy_mask", busy_mask, 64'h3FE);
      check("two_done_mask", done_mask, 64'h200);

      // ---------------- first record stalled for 10 cycles
      monitor(30, 10, 64'h1);
      check("stall_unstable",  unstable,  0);
      check("stall_nrec",      nrec,      2);
      check("stall_rec0_idx",  r_idx[0],  3'd2);
      check("stall_rec0_sum",  r_sum[0],  8'd3);
      check("stall_rec1_idx",  r_idx[1],  3'd5);
      check("stall_total",     tot_done,  11'd4);
      check("stall_busy_mask", busy_mask, 64'hFFFFE);
      check("stall_done_mask", done_mask, 64'h80000);

      // ---------------- triggers while busy collapse into one extra scan
      sum_in = '0;
      monitor(40, 0, 64'hA9);
      check("pend_busy_mask", busy_mask, 64'hFFBFE);
      check("pend_done_mask", done_mask, 64'h80200);

      // ---------------- auto-scan period 20
      period    = 16'd20;
      nstart    = 0;
      prev_busy = busy;
      for (int c = 0; c < 70; c++) begin
         if (busy && !prev_busy) begin
            if (nstart < 3) starts[nstart] = c;
            nstart++;
         end
         prev_busy = busy;
         step();
      end
      check("period_nstart", nstart, 3);
      check("period_gap1",   starts[1] - starts[0], 20);
      check("period_gap2",   starts[2] - starts[1], 20);

      for (int c = 0; c < 20 && busy; c++) step();
      check("period_idle", busy, 1'b0);
      period   = 16'd0;
      busy_cnt = 0;
      for (int c = 0; c < 60; c++) begin
         if (busy) busy_cnt++;
         step();
      end
      check("period0_no_scan", busy_cnt, 0);

      // ---------------- reset mid-scan aborts without done
      sum_in[2*8 +: 8] = 8'd3;
      scan_req = 1'b1;
      step();
      scan_req = 1'b0;
      repeat (2) step();
      check("abort_busy_before", busy, 1'b1);
      reset = 1'b1;
      step();
      check("abort_busy",      busy,      1'b0);
      check("abort_rec_valid", rec_valid, 1'b0);
      check("abort_total",     total,     11'd0);
      reset = 1'b0;
      busy_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         if (done || busy) busy_cnt++;
         step();
      end
      check("abort_no_done", busy_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
